fifo_burst_drain: RTL and testbench
===================================

Name: fifo_burst_drain

Overview:
Read-side consumer of the write-path FIFO. It pops words through the FIFO controller's read interface and collects BurstLen words into a local burst buffer. It then issues one SDRAM write-burst request with a req/ack handshake and streams the buffered words to the SDRAM controller on demand. It sits between the host write FIFO and the SDRAM command/data engine, and maintains an auto-incrementing SDRAM write address.

Parameters:
DataWidth, 16, FIFO and SDRAM data word width
AddrWidth, 24, SDRAM word address width
BurstLen, 8, words per burst; power of 2, >=2, < 2**AddrWidth

Ports:
i_clk  in  1  single clock
i_rst_n  in  1  synchronous active-low reset
i_base_load  in  1  load write-address pointer from i_base_addr
i_base_addr  in  AddrWidth  new write-address pointer value
i_fifo_empty  in  1  FIFO empty flag
o_fifo_rd_en  out  1  FIFO pop strobe
i_fifo_rd_data  in  DataWidth  FIFO read data, valid 1 cycle after o_fifo_rd_en
o_req  out  1  burst write request
o_req_addr  out  AddrWidth  burst start address, stable while o_req
i_ack  in  1  controller accepts request
i_data_req  in  1  controller pulls one data word this cycle
o_data  out  DataWidth  current burst word
o_burst_done  out  1  1-cycle pulse after the last word is pulled
o_busy  out  1  burst in progress

Behaviour:
- Reset values: o_fifo_rd_en=0, o_req=0, o_req_addr=0, o_data=0, o_burst_done=0, o_busy=0. Address pointer=0, all counters=0, state=FILL.
- Counter width: $clog2(BurstLen)+1 bits. Address arithmetic is modulo 2**AddrWidth (silent wrap).
- State FILL:
  - o_fifo_rd_en = !i_fifo_empty && (issued_cnt < BurstLen). This is combinational, so it is never asserted when the FIFO is empty.
  - issued_cnt increments on each pop.
  - Read latency is 1: on the cycle after a pop, i_fifo_rd_data is written to buf[capt_cnt] and capt_cnt increments.
  - When capt_cnt reaches BurstLen, go to REQ next cycle.
- State REQ:
  - o_req=1 and o_req_addr=addr_ptr, both held stable until i_ack is sampled high.
  - The cycle after ack: o_req=0 and go to SEND.
  - No pops in REQ, even when the FIFO is non-empty.
- State SEND:
  - o_data = buf[send_idx]; it holds its value while i_data_req=0.
  - Each cycle with i_data_req=1 consumes o_data, and send_idx increments.
  - On the cycle the BurstLen-th word is consumed: next cycle o_burst_done=1 for exactly one cycle, addr_ptr += BurstLen, all counters clear, and the state returns to FILL.
- i_base_load is honoured only in FILL and takes effect next cycle. It is ignored in REQ and SEND.
- i_ack outside REQ and i_data_req outside SEND are ignored.
- o_busy=1 when state!=FILL or issued_cnt!=0.
- Reset mid-burst: the next cycle is the reset state. Words already popped are discarded and not re-requested.
- o_data outside SEND: holds its last value (0 after reset).

Decomposition:
- Shared sdram_pkg contains: the drain state enum typedef (FILL, REQ, SEND) and default DataWidth/AddrWidth/BurstLen constants, shared with the SDRAM controller.
- One natural sub-module: burst_buf. It is a BurstLen x DataWidth register array with one synchronous write port (we, waddr, wdata) and one combinational read port. It has no reset on contents.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with FIFO non-empty -> all outputs 0, no o_fifo_rd_en.
- Basic burst:
  - Stimulus: i_base_addr=0x000100 loaded, FIFO preloaded with 0x1000..0x1007.
  - Required response: o_fifo_rd_en high for exactly 8 consecutive cycles, then o_req=1 with o_req_addr=0x000100.
  - Then ack is given and i_data_req is held high -> o_data=0x1000..0x1007 in order, o_burst_done pulses once, and the next o_req_addr=0x000108.
- Sparse FIFO: i_fifo_empty toggles every other cycle -> o_fifo_rd_en only while not empty, 8 pops total, data order preserved.
- Delayed ack: i_ack delayed 5 cycles with FIFO holding 16 words -> o_req/o_req_addr stable for all 5 cycles, zero pops during REQ.
- Pull gaps: i_data_req pattern 1,0,0,1,1,0,... -> o_data holds during gaps, exactly 8 words consumed, o_burst_done is only after the 8th.
- Wrap and reset:
  - base 0xFFFFF8 -> first burst at 0xFFFFF8, second at 0x000000.
  - Reset after 3 words are pulled in SEND -> next cycle outputs 0, and the next burst uses address 0x000000.

Source files
------------

// File: rtl/sdram_pkg.sv
// Types and default sizing shared between the SDRAM controller and the
// write-path burst drain.
package sdram_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } drain_state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 24;
  localparam int DEF_BURST_LEN  = 8;

endpackage

// File: rtl/burst_buf.sv
// Small register-array burst buffer: one synchronous write port and one
// combinational read port.
module burst_buf #(
  parameter int Depth = 8,
  parameter int Width = 16
) (
  input  logic                     i_clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [Width-1:0]         wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem [Depth];

  // NOTE: storage is deliberately left without reset; every entry is written
  // during FILL before it can be read in SEND, so a reset would only cost area.
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_burst_drain.sv
// Drains BurstLen words from the host write FIFO, requests one SDRAM write
// burst at an auto-incrementing address and streams the words on demand.
module fifo_burst_drain
  import sdram_pkg::*;
#(
  parameter int DataWidth = DEF_DATA_WIDTH,
  parameter int AddrWidth = DEF_ADDR_WIDTH,
  parameter int BurstLen  = DEF_BURST_LEN
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_base_load,
  input  logic [AddrWidth-1:0] i_base_addr,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rd_en,
  input  logic [DataWidth-1:0] i_fifo_rd_data,
  output logic                 o_req,
  output logic [AddrWidth-1:0] o_req_addr,
  input  logic                 i_ack,
  input  logic                 i_data_req,
  output logic [DataWidth-1:0] o_data,
  output logic                 o_burst_done,
  output logic                 o_busy
);

  localparam int IW = $clog2(BurstLen);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0]        BURST_CNT  = CW'(BurstLen);
  localparam logic [CW-1:0]        LAST_IDX   = CW'(BurstLen - 1);
  localparam logic [AddrWidth-1:0] ADDR_STEP  = AddrWidth'(BurstLen);

  drain_state_e state_q, state_d;

  logic [CW-1:0]        issued_cnt, capt_cnt, send_idx;
  logic [AddrWidth-1:0] addr_ptr;
  logic                 rd_en_q;
  logic                 done_q;
  logic [DataWidth-1:0] data_hold;
  logic [DataWidth-1:0] buf_rdata;

  logic pop, capture, capt_full, consume, last_consume;

  // Pop is combinational so it can never fire on an empty FIFO; gating with
  // reset keeps it quiet while the registers are being cleared.
  assign pop          = (state_q == FILL) && i_rst_n && !i_fifo_empty &&
                        (issued_cnt < BURST_CNT);
  assign capture      = rd_en_q;
  assign capt_full    = capture && (capt_cnt == LAST_IDX);
  assign consume      = (state_q == SEND) && i_data_req;
  assign last_consume = consume && (send_idx == LAST_IDX);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      FILL:    if (capt_full)    state_d = REQ;
      REQ:     if (i_ack)        state_d = SEND;
      SEND:    if (last_consume) state_d = FILL;
      default:                   state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= FILL;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      issued_cnt <= '0;
      capt_cnt   <= '0;
      send_idx   <= '0;
      addr_ptr   <= '0;
      rd_en_q    <= 1'b0;
      done_q     <= 1'b0;
      data_hold  <= '0;
    end else begin
      rd_en_q <= pop;
      done_q  <= last_consume;
      if (pop)     issued_cnt <= issued_cnt + 1'b1;
      if (capture) capt_cnt   <= capt_cnt + 1'b1;
      if (consume) send_idx   <= send_idx + 1'b1;
      if ((state_q == FILL) && i_base_load) addr_ptr <= i_base_addr;
      if (state_q == SEND) data_hold <= buf_rdata;
      if (last_consume) begin
        issued_cnt <= '0;
        capt_cnt   <= '0;
        send_idx   <= '0;
        addr_ptr   <= addr_ptr + ADDR_STEP;
      end
    end
  end

  burst_buf #(
    .Depth (BurstLen),
    .Width (DataWidth)
  ) u_buf (
    .i_clk (i_clk),
    .we    (capture),
    .waddr (capt_cnt[IW-1:0]),
    .wdata (i_fifo_rd_data),
    .raddr (send_idx[IW-1:0]),
    .rdata (buf_rdata)
  );

  // Outside SEND the buffer read port is not meaningful; show the last word sent.
  assign o_fifo_rd_en = pop;
  assign o_req        = (state_q == REQ);
  assign o_req_addr   = addr_ptr;
  assign o_data       = (state_q == SEND) ? buf_rdata : data_hold;
  assign o_burst_done = done_q;
  assign o_busy       = (state_q != FILL) || (issued_cnt != '0);

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Scoreboard bench for fifo_burst_drain: a FIFO model feeds words, the
// expected words are queued at push time and compared as the DUT streams them.
module tb_fifo_burst_drain;

  localparam int DW = 16;
  localparam int AW = 24;
  localparam int BL = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_base_load = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic          i_fifo_empty = 1'b1;
  logic          o_fifo_rd_en;
  logic [DW-1:0] i_fifo_rd_data = '0;
  logic          o_req;
  logic [AW-1:0] o_req_addr;
  logic          i_ack = 1'b0;
  logic          i_data_req = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_burst_done;
  logic          o_busy;

  always #5 i_clk = ~i_clk;

  fifo_burst_drain #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .BurstLen  (BL)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_base_load    (i_base_load),
    .i_base_addr    (i_base_addr),
    .i_fifo_empty   (i_fifo_empty),
    .o_fifo_rd_en   (o_fifo_rd_en),
    .i_fifo_rd_data (i_fifo_rd_data),
    .o_req          (o_req),
    .o_req_addr     (o_req_addr),
    .i_ack          (i_ack),
    .i_data_req     (i_data_req),
    .o_data         (o_data),
    .o_burst_done   (o_burst_done),
    .o_busy         (o_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model and scoreboard storage
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            pop_cyc[$];
  int            cyc = 0;
  bit            sparse = 1'b0;
  bit            starve = 1'b0;
  bit            pend = 1'b0;
  logic [DW-1:0] pend_word = '0;

  // Inputs change on the falling edge; pop data is presented one cycle later.
  always @(negedge i_clk) begin
    cyc++;
    if (pend) i_fifo_rd_data = pend_word;
    starve = sparse ? !starve : 1'b0;
    i_fifo_empty = (fifo_q.size() == 0) || starve;
    #1;
    check("pop_when_empty", 32'(o_fifo_rd_en & i_fifo_empty), 0);
    check("pop_in_req", 32'(o_fifo_rd_en & o_req), 0);
    pend = 1'b0;
    if (o_fifo_rd_en && fifo_q.size() > 0) begin
      pend_word = fifo_q.pop_front();
      pend = 1'b1;
      pop_cyc.push_back(cyc);
    end
  end

  task automatic push_words(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(first + DW'(i));
      exp_q.push_back(first + DW'(i));
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  // Entry and exit: 2 time units after a falling edge, outputs settled.
  task automatic do_burst(input logic [AW-1:0] exp_addr, input int ack_delay,
                          input bit gaps, input bit contig, input int pull_limit);
    int n = 0;
    int k = 0;
    int consumed = 0;
    logic [DW-1:0] last = '0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    while (!o_req && n < 200) begin
      step(); #2; n++;
    end
    if (!o_req) begin
      check("req_timeout", 0, 1);
      return;
    end
    check("req_addr", o_req_addr, 32'(exp_addr));
    check("pops_per_burst", pop_cyc.size(), BL);
    if (contig && pop_cyc.size() == BL) check("pop_span", pop_cyc[BL-1] - pop_cyc[0], BL - 1);
    if (!contig && pop_cyc.size() == BL) check("sparse_span_gt", 32'(pop_cyc[BL-1] - pop_cyc[0] > BL - 1), 1);
    pop_cyc.delete();
    check("busy_in_req", 32'(o_busy), 1);
    repeat (ack_delay) begin
      step(); #2;
      check("req_held", 32'(o_req), 1);
      check("req_addr_held", o_req_addr, 32'(exp_addr));
    end
    step(); i_ack = 1'b1; #2;
    step(); i_ack = 1'b0;
    while (consumed < pull_limit && k < 200) begin
      i_data_req = gaps ? pat[k % 6] : 1'b1;
      #2;
      if (k == 0) check("req_drop_after_ack", 32'(o_req), 0);
      check("data", 32'(o_data), exp_q.size() > 0 ? 32'(exp_q[0]) : 32'hDEAD);
      check("done_early", 32'(o_burst_done), 0);
      if (i_data_req) begin
        consumed++;
        if (exp_q.size() > 0) last = exp_q.pop_front();
      end
      k++;
      if (consumed < pull_limit) step();
    end
    if (consumed < pull_limit) check("pull_timeout", consumed, pull_limit);
    if (pull_limit < BL) return;
    step(); i_data_req = 1'b0; #2;
    check("burst_done", 32'(o_burst_done), 1);
    check("data_hold_after", 32'(o_data), 32'(last));
    step(); #2;
    check("done_one_cycle", 32'(o_burst_done), 0);
  endtask

  task automatic load_base(input logic [AW-1:0] a);
    step(); i_base_load = 1'b1; i_base_addr = a;
    step(); i_base_load = 1'b0; #2;
  endtask

  initial begin
    // Reset held with a non-empty FIFO
    push_words(16'h1000, BL);
    repeat (3) begin
      step(); #2;
      check("rst_rd_en", 32'(o_fifo_rd_en), 0);
      check("rst_req", 32'(o_req), 0);
      check("rst_req_addr", o_req_addr, 0);
      check("rst_data", 32'(o_data), 0);
      check("rst_done", 32'(o_burst_done), 0);
      check("rst_busy", 32'(o_busy), 0);
    end
    step(); i_rst_n = 1'b1; i_base_load = 1'b1; i_base_addr = 24'h000100; #2;
    check("first_pop", 32'(o_fifo_rd_en), 1);
    step(); i_base_load = 1'b0; #2;
    do_burst(24'h000100, 0, 1'b0, 1'b1, BL);

    // Sparse FIFO
    sparse = 1'b1;
    push_words(16'h2000, BL);
    do_burst(24'h000108, 0, 1'b0, 1'b0, BL);
    sparse = 1'b0;

    // Delayed ack with 16 words waiting, then pull gaps
    push_words(16'h3000, 2 * BL);
    do_burst(24'h000110, 5, 1'b0, 1'b1, BL);
    do_burst(24'h000118, 0, 1'b1, 1'b1, BL);

    // Address wrap
    load_base(24'hFFFFF8);
    push_words(16'h4000, 2 * BL);
    do_burst(24'hFFFFF8, 0, 1'b0, 1'b1, BL);
    do_burst(24'h000000, 0, 1'b1, 1'b1, BL);

    // Reset after three words pulled
    push_words(16'h5000, BL);
    do_burst(24'h000008, 0, 1'b0, 1'b1, 3);
    step(); i_data_req = 1'b0; i_rst_n = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    step(); #2;
    check("mid_rst_data", 32'(o_data), 0);
    check("mid_rst_req", 32'(o_req), 0);
    check("mid_rst_busy", 32'(o_busy), 0);
    check("mid_rst_rd_en", 32'(o_fifo_rd_en), 0);
    check("mid_rst_addr", o_req_addr, 0);
    pop_cyc.delete();
    push_words(16'h6000, BL);
    step(); i_rst_n = 1'b1; #2;
    do_burst(24'h000000, 0, 1'b0, 1'b1, BL);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
